jtag_confreg_bank: RTL and testbench
====================================

// Module: jtag_confreg_bank
// PURPOSE
// - Addressable bank of N_REGS JTAG configuration registers, each REG_WIDTH bits wide.
// - Sits behind the TAP confreg user-DR select; successor to the single fixed-width confreg.
// - One DR frame carries address, write flag and data. Capture returns SoC status for the
//   selected register, synchronised into the tck domain.
// PARAMETERS
// - N_REGS       4    number of registers (>=1); AW = max(1,$clog2(N_REGS)) address bits
// - REG_WIDTH    8    data bits per register (>=1)
// - SYNC_STAGES  2    flops on soc_reg_i before capture (>=2)
// - RESET_VALUE  '0   [N_REGS*REG_WIDTH-1:0] reset image of conf_reg_o; reg i at slice i
// PORTS
// - tck_i           in   1            JTAG TCK, only clock
// - trst_ni         in   1            async active-low reset
// - enable_i        in   1            confreg DR selected by TAP IR
// - capture_dr_i    in   1            TAP Capture-DR
// - shift_dr_i      in   1            TAP Shift-DR
// - update_dr_i     in   1            TAP Update-DR
// - scan_in_i       in   1            TDI from TAP
// - scan_out_o      out  1            LSB of shift register, to TAP
// - soc_reg_i       in   N_REGS*W     SoC status words, async to tck; reg i at slice i
// - conf_reg_o      out  N_REGS*W     configuration registers; reg i at slice i
// - update_pulse_o  out  N_REGS       1-cycle strobe after reg i is written
// - err_o           out  1            sticky frame error; tied 0 without parity
// BEHAVIOUR
// - Frame, L = W+1+AW(+1) bits:
//   - [W-1:0] data
//   - [W] wr
//   - [W+AW:W+1] addr
//   - [L-1] parity, only with the macro
// - Shift register sr[L-1:0], LSB out first. On tck rising edge with enable_i:
//   - capture_dr_i: sr <= {par, addr_q, err_o, rdata}
//   - else shift_dr_i: sr <= {scan_in_i, sr[L-1:1]}
//   - capture has priority over shift if both are high.
// - scan_out_o = sr[0], combinational from the flop.
// - rdata: synchronised soc_reg_i slice addr_q. rdata = 0 if addr_q >= N_REGS.
// - Update, on the edge with update_dr_i & enable_i:
//   - addr_q <= sr addr field.
//   - If wr=1 and addr < N_REGS: conf_reg_o[addr] <= sr data.
//     conf_reg_o is visible after that edge, 0-cycle added latency.
//   - update_pulse_o[addr] is high for exactly the next cycle (one tck).
//   - wr=0: address-only update, no write, no pulse.
//   - addr >= N_REGS: write silently dropped, no pulse; addr_q still latched.
// - Without enable_i, capture/shift/update are ignored. sr, registers and pulses hold/clear normally.
// - Synchroniser always runs: SYNC_STAGES flop chain, reset to 0.
// - Reset (any time, including mid-shift), all asynchronous:
//   - sr = 0, addr_q = 0, err_o = 0, update_pulse_o = 0
//   - conf_reg_o = RESET_VALUE, sync flops = 0
// CONFIGURATION
// - Macro: JTAG_CONFREG_PARITY_EN
// - Defined:
//   - Adds frame bit L-1; frames must have even parity (XOR of all L bits == 0).
//   - Capture sets par so the captured frame is even.
//   - Update with bad parity: no write, addr_q unchanged, no pulse, err_o <= 1.
//   - Update with good parity: normal behaviour, and err_o <= 0.
// - Undefined: L = W+1+AW, no parity bit, err_o = 0 constant. Captured bit [W] = 0.
// TESTING (defaults N_REGS=4, W=8, AW=2, L=11 without parity, 12 with)
// 1. Reset: trst_ni low mid-shift -> conf_reg_o = RESET_VALUE, scan_out_o = 0,
//    update_pulse_o = 0, err_o = 0.
// 2. Write: shift {addr=2, wr=1, data=8'hA5}, then update.
//    -> conf_reg_o[23:16] = 8'hA5; update_pulse_o = 4'b0100 for exactly one tck.
// 3. Readback: soc_reg_i[15:8] = 8'h3C, frame addr=1 wr=0, update.
//    Wait >= SYNC_STAGES tck, then capture and shift out.
//    -> data bits read 8'h3C, addr 1, no pulse.
// 4. Out of range: N_REGS=3, write addr=3 data=8'hFF.
//    -> no reg changes, no pulse. Next capture returns data 0 with addr 3.
// 5. enable_i low during capture/shift/update of a write frame
//    -> sr and conf_reg_o unchanged; scan_out_o stable.
// 6. Parity (macro defined): write with odd parity -> no write, err_o = 1.
//    Next capture shows bit[8] = 1. A good-parity frame then clears err_o and writes.

Source files
------------

// File: rtl/jtag_confreg_bank.sv
// Addressable bank of JTAG configuration registers behind a single user DR.
// Optional frame parity and sticky error flag: define JTAG_CONFREG_PARITY_EN.
module jtag_confreg_bank #(
  parameter int unsigned N_REGS      = 4,
  parameter int unsigned REG_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [N_REGS*REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          tck_i,
  input  logic                          trst_ni,
  input  logic                          enable_i,
  input  logic                          capture_dr_i,
  input  logic                          shift_dr_i,
  input  logic                          update_dr_i,
  input  logic                          scan_in_i,
  output logic                          scan_out_o,
  input  logic [N_REGS*REG_WIDTH-1:0]   soc_reg_i,
  output logic [N_REGS*REG_WIDTH-1:0]   conf_reg_o,
  output logic [N_REGS-1:0]             update_pulse_o,
  output logic                          err_o
);

  localparam int unsigned W  = REG_WIDTH;
  localparam int unsigned NW = N_REGS * REG_WIDTH;
  localparam int unsigned AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
`ifdef JTAG_CONFREG_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned L  = W + 1 + AW + PW;
  localparam logic [AW:0] NRegsW = (AW+1)'(N_REGS);

  logic [L-1:0]        r_sr;
  logic [AW-1:0]       r_addr;
  logic [NW-1:0]       r_conf;
  logic [N_REGS-1:0]   r_pulse;
  logic [NW-1:0]       r_sync [SYNC_STAGES];

  logic [W-1:0]        w_data;
  logic                w_wr;
  logic [AW-1:0]       w_addr;
  logic                w_addr_ok;
  logic [W-1:0]        w_rdata;
  logic [L-PW-1:0]     w_cap_body;
  logic [L-1:0]        w_cap;
  logic                w_par_ok;
  logic                w_err;
  logic                w_upd;
  logic                w_upd_ok;
  logic [N_REGS-1:0]   w_wr_sel;

  assign w_data     = r_sr[W-1:0];
  assign w_wr       = r_sr[W];
  assign w_addr     = r_sr[W+AW:W+1];
  assign w_addr_ok  = ({1'b0, w_addr} < NRegsW);
  assign w_upd      = enable_i & update_dr_i;
  assign w_upd_ok   = w_upd & w_par_ok;
  assign w_cap_body = {r_addr, w_err, w_rdata};

`ifdef JTAG_CONFREG_PARITY_EN
  logic r_err;

  // Parity bit chosen so the captured frame XORs to zero.
  assign w_cap    = {^w_cap_body, w_cap_body};
  assign w_par_ok = ~^r_sr;
  assign w_err    = r_err;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_err <= 1'b0;
    end else if (w_upd) begin
      r_err <= ~w_par_ok;
    end
  end
`else
  assign w_cap    = w_cap_body;
  assign w_par_ok = 1'b1;
  assign w_err    = 1'b0;
`endif

  // Readback mux over the synchronised status; out-of-range addresses read zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      if (r_addr == AW'(i)) begin
        w_rdata = r_sync[SYNC_STAGES-1][i*W +: W];
      end
    end
  end

  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      w_wr_sel[i] = w_upd_ok & w_wr & w_addr_ok & (w_addr == AW'(i));
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_sr <= '0;
    end else if (enable_i && capture_dr_i) begin
      r_sr <= w_cap;
    end else if (enable_i && shift_dr_i) begin
      r_sr <= {scan_in_i, r_sr[L-1:1]};
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_addr <= '0;
    end else if (w_upd_ok) begin
      r_addr <= w_addr;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_conf  <= RESET_VALUE;
      r_pulse <= '0;
    end else begin
      r_pulse <= w_wr_sel;
      for (int i = 0; i < int'(N_REGS); i++) begin
        if (w_wr_sel[i]) begin
          r_conf[i*W +: W] <= w_data;
        end
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= soc_reg_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign scan_out_o     = r_sr[0];
  assign conf_reg_o     = r_conf;
  assign update_pulse_o = r_pulse;
  assign err_o          = w_err;

endmodule

// File: tb/tb_jtag_confreg_bank.sv
// Directed bench for jtag_confreg_bank: a 4-register and a 3-register instance share one TAP.
module tb_jtag_confreg_bank;

`ifdef JTAG_CONFREG_PARITY_EN
  localparam int FL = 12;
`else
  localparam int FL = 11;
`endif
  localparam logic [31:0] RV4 = 32'h1122_3344;
  localparam logic [23:0] RV3 = 24'hAB_CDEF;

  logic        tck = 1'b0;
  logic        trst_n;
  logic        en, cap, sh, upd, tdi;
  logic        tdo4, tdo3;
  logic [31:0] soc4, conf4;
  logic [23:0] soc3, conf3;
  logic [3:0]  pulse4;
  logic [2:0]  pulse3;
  logic        err4, err3;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  jtag_confreg_bank #(
    .N_REGS(4), .REG_WIDTH(8), .SYNC_STAGES(2), .RESET_VALUE(RV4)
  ) dut (
    .tck_i(tck), .trst_ni(trst_n), .enable_i(en), .capture_dr_i(cap),
    .shift_dr_i(sh), .update_dr_i(upd), .scan_in_i(tdi), .scan_out_o(tdo4),
    .soc_reg_i(soc4), .conf_reg_o(conf4), .update_pulse_o(pulse4), .err_o(err4)
  );

  jtag_confreg_bank #(
    .N_REGS(3), .REG_WIDTH(8), .SYNC_STAGES(2), .RESET_VALUE(RV3)
  ) dut3 (
    .tck_i(tck), .trst_ni(trst_n), .enable_i(en), .capture_dr_i(cap),
    .shift_dr_i(sh), .update_dr_i(upd), .scan_in_i(tdi), .scan_out_o(tdo3),
    .soc_reg_i(soc3), .conf_reg_o(conf3), .update_pulse_o(pulse3), .err_o(err3)
  );

  function automatic logic [FL-1:0] mk(input logic [1:0] a, input logic wr, input logic [7:0] d);
    logic [10:0] body;
    body = {a, wr, d};
`ifdef JTAG_CONFREG_PARITY_EN
    return {^body, body};
`else
    return body;
`endif
  endfunction

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_frame(input logic [FL-1:0] f, output logic [FL-1:0] o4,
                             output logic [FL-1:0] o3);
    en = 1'b1;
    sh = 1'b1;
    for (int i = 0; i < FL; i++) begin
      tdi   = f[i];
      o4[i] = tdo4;
      o3[i] = tdo3;
      tick();
    end
    sh  = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic do_update();
    en  = 1'b1;
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic do_capture();
    en  = 1'b1;
    cap = 1'b1;
    tick();
    cap = 1'b0;
  endtask

  task automatic test_reset();
    trst_n = 1'b0;
    en = 0; cap = 0; sh = 0; upd = 0; tdi = 0;
    soc4 = 32'h0000_3C00;
    soc3 = 24'hFF_FFFF;
    #12 trst_n = 1'b1;
    tick();
    checks++; if (conf4 !== RV4) begin errors++;
      $display("FAIL reset_conf4 got %h want %h", conf4, RV4); end
    checks++; if (conf3 !== RV3) begin errors++;
      $display("FAIL reset_conf3 got %h want %h", conf3, RV3); end
    checks++; if (tdo4 !== 1'b0) begin errors++;
      $display("FAIL reset_tdo got %b want 0", tdo4); end
    checks++; if (pulse4 !== 4'b0000) begin errors++;
      $display("FAIL reset_pulse got %b want 0000", pulse4); end
    checks++; if (err4 !== 1'b0) begin errors++;
      $display("FAIL reset_err got %b want 0", err4); end
  endtask

  task automatic test_write();
    logic [FL-1:0] o4, o3;
    shift_frame(mk(2'd2, 1'b1, 8'hA5), o4, o3);
    checks++; if (pulse4 !== 4'b0000) begin errors++;
      $display("FAIL write_pre_pulse got %b want 0000", pulse4); end
    do_update();
    checks++; if (conf4 !== 32'h11A5_3344) begin errors++;
      $display("FAIL write_conf4 got %h want 11a53344", conf4); end
    checks++; if (pulse4 !== 4'b0100) begin errors++;
      $display("FAIL write_pulse got %b want 0100", pulse4); end
    checks++; if (conf3 !== 24'hA5_CDEF) begin errors++;
      $display("FAIL write_conf3 got %h want a5cdef", conf3); end
    tick();
    checks++; if (pulse4 !== 4'b0000) begin errors++;
      $display("FAIL write_pulse_len got %b want 0000", pulse4); end
  endtask

  task automatic test_readback();
    logic [FL-1:0] o4, o3;
    shift_frame(mk(2'd1, 1'b0, 8'h00), o4, o3);
    do_update();
    checks++; if (pulse4 !== 4'b0000) begin errors++;
      $display("FAIL rb_pulse got %b want 0000", pulse4); end
    checks++; if (conf4 !== 32'h11A5_3344) begin errors++;
      $display("FAIL rb_conf4 got %h want 11a53344", conf4); end
    tick(); tick(); tick();
    do_capture();
    shift_frame('0, o4, o3);
    checks++; if (o4[7:0] !== 8'h3C) begin errors++;
      $display("FAIL rb_data got %h want 3c", o4[7:0]); end
    checks++; if (o4[10:9] !== 2'd1) begin errors++;
      $display("FAIL rb_addr got %0d want 1", o4[10:9]); end
    checks++; if (o4[8] !== 1'b0) begin errors++;
      $display("FAIL rb_bit8 got %b want 0", o4[8]); end
`ifdef JTAG_CONFREG_PARITY_EN
    checks++; if (^o4 !== 1'b0) begin errors++;
      $display("FAIL rb_parity got %b want 0", ^o4); end
`endif
  endtask

  task automatic test_out_of_range();
    logic [FL-1:0] o4, o3;
    shift_frame(mk(2'd3, 1'b1, 8'hFF), o4, o3);
    do_update();
    checks++; if (conf3 !== 24'hA5_CDEF) begin errors++;
      $display("FAIL oor_conf3 got %h want a5cdef", conf3); end
    checks++; if (pulse3 !== 3'b000) begin errors++;
      $display("FAIL oor_pulse3 got %b want 000", pulse3); end
    checks++; if (pulse4 !== 4'b1000) begin errors++;
      $display("FAIL oor_pulse4 got %b want 1000", pulse4); end
    checks++; if (conf4 !== 32'hFFA5_3344) begin errors++;
      $display("FAIL oor_conf4 got %h want ffa53344", conf4); end
    tick(); tick(); tick();
    do_capture();
    shift_frame('0, o4, o3);
    checks++; if (o3[7:0] !== 8'h00) begin errors++;
      $display("FAIL oor_rdata got %h want 00", o3[7:0]); end
    checks++; if (o3[10:9] !== 2'd3) begin errors++;
      $display("FAIL oor_addr got %0d want 3", o3[10:9]); end
  endtask

  task automatic test_disabled();
    logic [FL-1:0] o4, o3;
    logic          ok;
    shift_frame('1, o4, o3);
    checks++; if (tdo4 !== 1'b1) begin errors++;
      $display("FAIL dis_preload got %b want 1", tdo4); end
    en = 1'b0; cap = 1'b1; sh = 1'b1; upd = 1'b1; tdi = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tdo4 !== 1'b1 || pulse4 !== 4'b0000 || pulse3 !== 3'b000) ok = 1'b0;
    end
    cap = 1'b0; sh = 1'b0; upd = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++;
      $display("FAIL dis_stable got %b want 1", ok); end
    checks++; if (conf4 !== 32'hFFA5_3344) begin errors++;
      $display("FAIL dis_conf4 got %h want ffa53344", conf4); end
    shift_frame('0, o4, o3);
    checks++; if (o4 !== {FL{1'b1}}) begin errors++;
      $display("FAIL dis_sr got %h want %h", o4, {FL{1'b1}}); end
  endtask

  task automatic test_back_to_back();
    logic [FL-1:0] o4, o3;
    shift_frame(mk(2'd0, 1'b1, 8'h12), o4, o3);
    do_update();
    checks++; if (pulse4 !== 4'b0001) begin errors++;
      $display("FAIL b2b_pulse0 got %b want 0001", pulse4); end
    shift_frame(mk(2'd1, 1'b1, 8'h34), o4, o3);
    do_update();
    checks++; if (pulse4 !== 4'b0010) begin errors++;
      $display("FAIL b2b_pulse1 got %b want 0010", pulse4); end
    checks++; if (conf4 !== 32'hFFA5_3412) begin errors++;
      $display("FAIL b2b_conf4 got %h want ffa53412", conf4); end
    checks++; if (conf3 !== 24'hA5_3412) begin errors++;
      $display("FAIL b2b_conf3 got %h want a53412", conf3); end
  endtask

`ifdef JTAG_CONFREG_PARITY_EN
  task automatic test_parity();
    logic [FL-1:0] o4, o3;
    logic [FL-1:0] bad;
    bad = mk(2'd0, 1'b1, 8'h55);
    bad[FL-1] = ~bad[FL-1];
    shift_frame(bad, o4, o3);
    do_update();
    checks++; if (err4 !== 1'b1) begin errors++;
      $display("FAIL par_err_set got %b want 1", err4); end
    checks++; if (conf4 !== 32'hFFA5_3412) begin errors++;
      $display("FAIL par_nowrite got %h want ffa53412", conf4); end
    checks++; if (pulse4 !== 4'b0000) begin errors++;
      $display("FAIL par_nopulse got %b want 0000", pulse4); end
    do_capture();
    shift_frame('0, o4, o3);
    checks++; if (o4 !== 12'b0_01_1_00111100) begin errors++;
      $display("FAIL par_capture got %b want 001100111100", o4); end
    shift_frame(mk(2'd0, 1'b1, 8'h55), o4, o3);
    do_update();
    checks++; if (err4 !== 1'b0) begin errors++;
      $display("FAIL par_err_clr got %b want 0", err4); end
    checks++; if (conf4 !== 32'hFFA5_3455) begin errors++;
      $display("FAIL par_write got %h want ffa53455", conf4); end
    checks++; if (pulse4 !== 4'b0001) begin errors++;
      $display("FAIL par_pulse got %b want 0001", pulse4); end
  endtask
`endif

  task automatic test_reset_midshift();
    logic [FL-1:0] o4, o3;
    shift_frame('1, o4, o3);
    checks++; if (tdo4 !== 1'b1) begin errors++;
      $display("FAIL mid_preload got %b want 1", tdo4); end
    en = 1'b1; sh = 1'b1; tdi = 1'b1;
    #2 trst_n = 1'b0;
    #1;
    checks++; if (tdo4 !== 1'b0) begin errors++;
      $display("FAIL mid_tdo got %b want 0", tdo4); end
    checks++; if (conf4 !== RV4) begin errors++;
      $display("FAIL mid_conf4 got %h want %h", conf4, RV4); end
    checks++; if (conf3 !== RV3) begin errors++;
      $display("FAIL mid_conf3 got %h want %h", conf3, RV3); end
    checks++; if (pulse4 !== 4'b0000 || err4 !== 1'b0) begin errors++;
      $display("FAIL mid_pulse_err got %b/%b want 0000/0", pulse4, err4); end
    en = 1'b0; sh = 1'b0; tdi = 1'b0;
    #2 trst_n = 1'b1;
    tick();
    checks++; if (conf4 !== RV4) begin errors++;
      $display("FAIL mid_hold got %h want %h", conf4, RV4); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_out_of_range();
    test_disabled();
    test_back_to_back();
`ifdef JTAG_CONFREG_PARITY_EN
    test_parity();
`endif
    test_reset_midshift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
